// File: rtl/qea_host_sequencer.sv
// Host-side initiator for the QEA core: loads gate context, seeds |0...0>,
// runs the core while timing it, then streams the state RAM back out.
module qea_host_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = DATA_WIDTH * 2,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH * 2,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LAT                  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_cmd,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word,
  output logic                                 o_amp_valid,
  input  logic                                 i_amp_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_amp_data,
  output logic                                 o_amp_last,
  output logic                                 o_busy,
  output logic                                 o_err,
  output logic [31:0]                          o_exec_cycles,
  output logic                                 o_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout
);

  localparam int AMP_W = PE_NUM * STATE_DATA_WIDTH;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_CTX = 3'd1;
  localparam logic [2:0] S_INIT     = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_RUN      = 3'd4;
  localparam logic [2:0] S_RD_ISSUE = 3'd5;
  localparam logic [2:0] S_RD_WAIT  = 3'd6;
  localparam logic [2:0] S_RD_HOLD  = 3'd7;

  // Real part of the top lane = 1.0 in fixed point; every other amplitude is zero.
  localparam logic [AMP_W-1:0] INIT_WORD =
    AMP_W'(1) << (AMP_W - STATE_DATA_WIDTH + DATA_WIDTH + NUM_FRAC_BIT);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN  = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX  = MAX_QBIT_WIDTH'(PE_NUM_WIDTH + STATE_ADDR_WIDTH);
  localparam logic [2:0]                WAIT_LAST = 3'(RD_LAT - 1);

  logic [2:0]                         r_state;
  logic [MAX_QBIT_WIDTH-1:0]          r_qbit_num;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ins_num;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ctx_addr;
  logic [STATE_ADDR_WIDTH-1:0]        r_last_addr;
  logic [STATE_ADDR_WIDTH-1:0]        r_addr;
  logic [2:0]                         r_wait;
  logic [31:0]                        r_cnt;
  logic                               r_first;
  logic [31:0]                        r_exec;
  logic [AMP_W-1:0]                   r_amp_data;
  logic                               r_err;

  logic                        w_cmd_legal;
  logic [STATE_ADDR_WIDTH-1:0] w_last_addr;
  logic                        w_ctx_fire;

  assign w_cmd_legal = (i_qbit_num >= QBIT_MIN) && (i_qbit_num <= QBIT_MAX);
  // N-1 as a low-order mask; stays in range even for N = 2**STATE_ADDR_WIDTH.
  assign w_last_addr = ~({STATE_ADDR_WIDTH{1'b1}} << (i_qbit_num - QBIT_MIN));
  assign w_ctx_fire  = (r_state == S_LOAD_CTX) && i_ctx_valid;

  assign o_busy        = (r_state != S_IDLE);
  assign o_ctx_ready   = (r_state == S_LOAD_CTX);
  assign o_ctx_en      = w_ctx_fire;
  assign o_ctx_wea     = w_ctx_fire;
  assign o_ctx_addr    = r_ctx_addr;
  assign o_ctx_data    = w_ctx_fire ? i_ctx_word : '0;
  assign o_start       = (r_state == S_START);
  assign o_qbit_num    = r_qbit_num;
  assign o_state_ena   = (r_state == S_INIT) || (r_state == S_RD_ISSUE);
  assign o_state_wea   = (r_state == S_INIT);
  assign o_state_addra = r_addr;
  assign o_state_dina  = ((r_state == S_INIT) && (r_addr == '0)) ? INIT_WORD : '0;
  assign o_amp_valid   = (r_state == S_RD_HOLD);
  assign o_amp_data    = r_amp_data;
  assign o_amp_last    = (r_state == S_RD_HOLD) && (r_addr == r_last_addr);
  assign o_exec_cycles = r_exec;
  assign o_err         = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_qbit_num  <= '0;
      r_ins_num   <= '0;
      r_ctx_addr  <= '0;
      r_last_addr <= '0;
      r_addr      <= '0;
      r_wait      <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b0;
      r_exec      <= '0;
      r_amp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd) begin
            if (w_cmd_legal) begin
              r_err       <= 1'b0;
              r_qbit_num  <= i_qbit_num;
              r_ins_num   <= i_ins_num;
              r_last_addr <= w_last_addr;
              r_ctx_addr  <= '0;
              r_addr      <= '0;
              r_state     <= (i_ins_num == '0) ? S_INIT : S_LOAD_CTX;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD_CTX: begin
          if (w_ctx_fire) begin
            r_ctx_addr <= r_ctx_addr + GATE_CONTEXT_ADDR_WIDTH'(1);
            if (r_ctx_addr == r_ins_num - GATE_CONTEXT_ADDR_WIDTH'(1)) r_state <= S_INIT;
          end
        end
        S_INIT: begin
          if (r_addr == r_last_addr) begin
            r_addr  <= '0;
            r_state <= S_START;
          end else begin
            r_addr <= r_addr + STATE_ADDR_WIDTH'(1);
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_first <= 1'b1;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Reported count = clock edges from the one sampling o_start to the one sampling i_complete.
          r_first <= 1'b0;
          if (i_complete && !r_first) begin
            r_exec  <= r_cnt + 32'd1;
            r_addr  <= '0;
            r_state <= S_RD_ISSUE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RD_ISSUE: begin
          r_wait  <= '0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_amp_data <= i_state_dout;
            r_state    <= S_RD_HOLD;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_RD_HOLD: begin
          if (i_amp_ready) begin
            if (r_addr == r_last_addr) begin
              r_state <= S_IDLE;
            end else begin
              r_addr  <= r_addr + STATE_ADDR_WIDTH'(1);
              r_state <= S_RD_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
